// File: rtl/hazard_pkg.sv
// Shared types for the hazard sequencer: FSM states and the in-flight destination tag.
package hazard_pkg;

  localparam int REG_AW = 4;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } stateT;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
  } tagT;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of ID/MEM inputs and pipeline-control outputs between the core and the sequencer.
interface hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_regwrite;
  logic [REG_AW-1:0] id_rd;
  logic              mem_pcsrc;
  logic [31:0]       mem_pc_target;

  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              issue;
  logic              pc_load;
  logic [31:0]       pc_value;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_regwrite, id_rd,
           mem_pcsrc, mem_pc_target,
    input  stall_pc, stall_if_id, flush_if_id, flush_id_ex, issue, pc_load, pc_value,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_regwrite, id_rd,
           mem_pcsrc, mem_pc_target,
    output stall_pc, stall_if_id, flush_if_id, flush_id_ex, issue, pc_load, pc_value,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_tag_pipe.sv
// Destination-tag shift register (EX, MEM, WB) with RAW compare for the two ID source ports.
module hazard_tag_pipe #(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 4,
  parameter bit R0_ZERO    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [REG_AW-1:0] pushRd,
  input  logic              squashEx,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              match1,
  output logic              match2
);
  import hazard_pkg::*;

  tagT slots [PIPE_DEPTH];

  // The back end never stalls, so tags advance every cycle; a redirect kills the EX tag as it moves to MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) slots[k] <= '0;
    end else begin
      slots[0].valid <= push & ~(R0_ZERO & (pushRd == '0));
      slots[0].rd    <= pushRd;
      for (int k = 1; k < PIPE_DEPTH; k++) slots[k] <= slots[k-1];
      if (squashEx) slots[1].valid <= 1'b0;
    end
  end

  // WB is still compared because the register file only writes at the closing edge.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (slots[k].valid && (slots[k].rd == rs1)) match1 = 1'b1;
      if (slots[k].valid && (slots[k].rd == rs2)) match2 = 1'b1;
    end
    if (R0_ZERO && (rs1 == '0)) match1 = 1'b0;
    if (R0_ZERO && (rs2 == '0)) match2 = 1'b0;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: RAW stall detection, branch redirect with wrong-path squash, perf counters.
module hazard_ctrl #(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 4,
  parameter bit R0_ZERO    = 1'b1,
  parameter int CNT_W      = 16
) (
  input logic           clk,
  input logic           rst,
  hazard_ctrl_if.slave  bus
);
  import hazard_pkg::*;

  stateT state;
  stateT stateNext;
  logic  match1;
  logic  match2;
  logic  hazard;
  logic  redirectNow;
  logic  stallNow;

  hazard_tag_pipe #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .REG_AW     (REG_AW),
    .R0_ZERO    (R0_ZERO)
  ) tagPipe (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.issue & bus.id_regwrite),
    .pushRd   (bus.id_rd),
    .squashEx (redirectNow),
    .rs1      (bus.id_rs1),
    .rs2      (bus.id_rs2),
    .match1   (match1),
    .match2   (match2)
  );

  assign hazard = bus.id_valid & ((bus.id_use_rs1 & match1) | (bus.id_use_rs2 & match2));

  // A taken branch outranks a hazard: the stalled instruction is on the wrong path anyway.
  always_comb begin
    stateNext       = state;
    redirectNow     = 1'b0;
    stallNow        = 1'b0;
    bus.stall_pc    = 1'b0;
    bus.stall_if_id = 1'b0;
    bus.flush_if_id = 1'b0;
    bus.flush_id_ex = 1'b0;
    bus.issue       = 1'b0;
    case (state)
      RUN: begin
        if (bus.mem_pcsrc) begin
          bus.flush_if_id = 1'b1;
          bus.flush_id_ex = 1'b1;
          redirectNow     = 1'b1;
          stateNext       = REDIRECT;
        end else if (hazard) begin
          bus.stall_pc    = 1'b1;
          bus.stall_if_id = 1'b1;
          bus.flush_id_ex = 1'b1;
          stallNow        = 1'b1;
        end else begin
          bus.issue = bus.id_valid;
        end
      end
      REDIRECT: begin
        bus.flush_if_id = 1'b1;
        bus.flush_id_ex = 1'b1;
        stateNext       = RUN;
      end
    endcase
  end

  // pc_load is high for exactly the REDIRECT cycle; pc_value keeps the last target afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      bus.pc_load   <= 1'b0;
      bus.pc_value  <= 32'h0;
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      state       <= stateNext;
      bus.pc_load <= redirectNow;
      if (redirectNow) bus.pc_value <= bus.mem_pc_target;
      if (stallNow && (bus.stall_cnt != {CNT_W{1'b1}}))
        bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
      if (redirectNow && (bus.flush_cnt != {CNT_W{1'b1}}))
        bus.flush_cnt <= bus.flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-indexed scoreboard of in-flight writes.
module tb_hazard_ctrl;

  logic clk;
  logic rst;

  hazard_ctrl_if #(.REG_AW(4), .CNT_W(16)) bus ();

  hazard_ctrl #(
    .PIPE_DEPTH (3),
    .REG_AW     (4),
    .R0_ZERO    (1'b1),
    .CNT_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int rd;
    int cyc;
    bit squashed;
  } writeT;

  writeT inFlight[$];
  int    cyc;
  bit    mRedirect;
  int    mPcValue;
  int    mStallCnt;
  int    mFlushCnt;
  int    compared;
  int    mismatched;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // A register is busy if a surviving write was issued 1..3 cycles ago (EX, MEM or WB).
  function automatic bit busyReg(input int r);
    if (r == 0) return 1'b0;
    foreach (inFlight[i]) begin
      if (!inFlight[i].squashed && inFlight[i].rd == r &&
          (cyc - inFlight[i].cyc) >= 1 && (cyc - inFlight[i].cyc) <= 3)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic applyStimulus(input bit r, input bit v, input int rs1, input int rs2,
                               input bit u1, input bit u2, input bit rw, input int rd,
                               input bit pc, input logic [31:0] tgt);
    bit hz;
    bit expStallPc, expStallIf, expFlushIf, expFlushEx, expIssue;
    @(negedge clk);
    rst                = r;
    bus.id_valid       = v;
    bus.id_rs1         = 4'(rs1);
    bus.id_rs2         = 4'(rs2);
    bus.id_use_rs1     = u1;
    bus.id_use_rs2     = u2;
    bus.id_regwrite    = rw;
    bus.id_rd          = 4'(rd);
    bus.mem_pcsrc      = pc;
    bus.mem_pc_target  = tgt;
    #1;
    hz = v && ((u1 && busyReg(rs1)) || (u2 && busyReg(rs2)));
    expStallPc = 1'b0; expStallIf = 1'b0; expFlushIf = 1'b0; expFlushEx = 1'b0; expIssue = 1'b0;
    if (mRedirect) begin
      expFlushIf = 1'b1; expFlushEx = 1'b1;
    end else if (pc) begin
      expFlushIf = 1'b1; expFlushEx = 1'b1;
    end else if (hz) begin
      expStallPc = 1'b1; expStallIf = 1'b1; expFlushEx = 1'b1;
    end else begin
      expIssue = v;
    end
    if (!r) begin
      checkOutput("stall_pc",    32'(bus.stall_pc),    32'(expStallPc));
      checkOutput("stall_if_id", 32'(bus.stall_if_id), 32'(expStallIf));
      checkOutput("flush_if_id", 32'(bus.flush_if_id), 32'(expFlushIf));
      checkOutput("flush_id_ex", 32'(bus.flush_id_ex), 32'(expFlushEx));
      checkOutput("issue",       32'(bus.issue),       32'(expIssue));
    end
    checkOutput("pc_load",   32'(bus.pc_load),   32'(mRedirect));
    checkOutput("pc_value",  bus.pc_value,       32'(mPcValue));
    checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(mStallCnt));
    checkOutput("flush_cnt", 32'(bus.flush_cnt), 32'(mFlushCnt));
    @(posedge clk);
    if (r) begin
      inFlight.delete();
      mRedirect = 1'b0;
      mPcValue  = 0;
      mStallCnt = 0;
      mFlushCnt = 0;
    end else if (mRedirect) begin
      mRedirect = 1'b0;
    end else if (pc) begin
      mRedirect = 1'b1;
      mPcValue  = int'(tgt);
      if (mFlushCnt < 65535) mFlushCnt++;
      foreach (inFlight[i]) if (inFlight[i].cyc == cyc - 1) inFlight[i].squashed = 1'b1;
    end else if (hz) begin
      if (mStallCnt < 65535) mStallCnt++;
    end else if (v && rw && rd != 0) begin
      inFlight.push_back('{rd: rd, cyc: cyc, squashed: 1'b0});
    end
    cyc++;
    while (inFlight.size() > 0 && (cyc - inFlight[0].cyc) > 3) void'(inFlight.pop_front());
  endtask

  task automatic idle(input bit r);
    applyStimulus(r, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0);
  endtask

  initial begin
    compared = 0; mismatched = 0; cyc = 0;
    mRedirect = 1'b0; mPcValue = 0; mStallCnt = 0; mFlushCnt = 0;
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0;
    bus.id_use_rs2 = 1'b0; bus.id_regwrite = 1'b0; bus.id_rd = '0;
    bus.mem_pcsrc = 1'b0; bus.mem_pc_target = 32'h0;

    $display("[TB] reset");
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    $display("[TB] RAW stall on r5");
    applyStimulus(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 5, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    #1 checkOutput("rawStallCnt", 32'(bus.stall_cnt), 32'd3);

    $display("[TB] r0 and unused rs2");
    applyStimulus(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 0, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    #1 checkOutput("r0StallCnt", 32'(bus.stall_cnt), 32'd3);

    $display("[TB] redirect to 0x40");
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0040);
    idle(1'b0);
    idle(1'b0);
    #1 checkOutput("redirFlushCnt", 32'(bus.flush_cnt), 32'd1);
    checkOutput("redirPcValue", bus.pc_value, 32'h40);

    $display("[TB] squash of EX write r7");
    applyStimulus(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 7, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0100);
    idle(1'b0);
    applyStimulus(1'b0, 1'b1, 7, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0);

    $display("[TB] hazard and redirect together, reset during redirect");
    applyStimulus(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 9, 0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0200);
    #1 checkOutput("simulStallCnt", 32'(bus.stall_cnt), 32'd3);
    idle(1'b1);
    idle(1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 3) != 0,
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) != 0, int'($urandom_range(0, 6)),
                    $urandom_range(0, 9) == 0, $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
